// File: rtl/alu_pkg.sv
// Shared types and sizing for the bit-serial ALU: operation codes, FSM states
// and the datapath width / bit-index width.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_cell.sv
// One-bit ALU slice: decodes the operation and produces the result bit and the
// carry to feed into the next bit position.
module serial_alu_cell
    import alu_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       s,
    output logic       cnext
);

    logic bx;

    // Subtraction is addition of the inverted operand with the carry preset to 1.
    always_comb begin
        s     = 1'b0;
        cnext = 1'b0;
        bx    = b;
        case (alu_op_t'(op))
            OP_ADD, OP_SUB: begin
                bx    = (alu_op_t'(op) == OP_SUB) ? ~b : b;
                s     = a ^ bx ^ c;
                cnext = (a & bx) | (a & c) | (bx & c);
            end
            OP_AND: s = a & b;
            OP_XOR: s = a ^ b;
            default: begin
                s     = 1'b0;
                cnext = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial 16-bit ALU: accepts an operation in IDLE, processes one bit per
// clock in RUN (sel = bit index), then pulses done for one cycle.
module bit_serial_alu
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               cout
);

    state_t             state;
    alu_op_t            opreg;
    logic [WIDTH-1:0]   areg;
    logic [WIDTH-1:0]   breg;
    logic               carry;
    logic               bit_s;
    logic               bit_c;

    serial_alu_cell u_cell (
        .op    (opreg),
        .a     (areg[sel]),
        .b     (breg[sel]),
        .c     (carry),
        .s     (bit_s),
        .cnext (bit_c)
    );

    // sel doubles as the bit counter; it wraps to 0 on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opreg  <= OP_ADD;
            areg   <= '0;
            breg   <= '0;
            carry  <= 1'b0;
            sel    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        areg   <= a;
                        breg   <= b;
                        opreg  <= alu_op_t'(op);
                        sel    <= '0;
                        result <= '0;
                        cout   <= 1'b0;
                        carry  <= (alu_op_t'(op) == OP_ADD) ? cin :
                                  (alu_op_t'(op) == OP_SUB);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result[sel] <= bit_s;
                    carry       <= bit_c;
                    sel         <= sel + 1'b1;
                    if (sel == IDX_W'(WIDTH - 1)) begin
                        cout  <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed self-checking bench for bit_serial_alu: arithmetic/logic results,
// latency, busy width, ignored starts, mid-run reset and back-to-back starts.
module tb_bit_serial_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;

    int tests    = 0;
    int failures = 0;

    bit_serial_alu dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci);
        @(negedge clk);
        op    = o;
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one operation to completion; optionally disturbs the inputs mid-run.
    task automatic runOp(input string tag, input logic [1:0] o, input logic [15:0] av,
                         input logic [15:0] bv, input logic ci, input logic [15:0] expRes,
                         input logic expCout, input bit disturb);
        int         cyc;
        int         busyCount;
        logic [3:0] selMid;
        bit         seen;
        applyStimulus(o, av, bv, ci);
        checkOutput({tag, " busy_at_accept"}, 32'(busy), 32'd1);
        checkOutput({tag, " sel_at_accept"}, 32'(sel), 32'd0);
        busyCount = int'(busy);
        cyc       = 0;
        seen      = 1'b0;
        selMid    = 4'd0;
        while (!seen && cyc < 40) begin
            if (disturb && cyc == 5) begin
                start = 1'b1;
                a     = 16'hFFFF;
                b     = 16'hFFFF;
                op    = 2'd1;
                cin   = 1'b1;
            end else if (disturb && cyc == 6) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busyCount++;
            if (cyc == 7) selMid = sel;
            if (done) seen = 1'b1;
        end
        checkOutput({tag, " done_latency"}, 32'(cyc), 32'd16);
        checkOutput({tag, " result"}, 32'(result), 32'(expRes));
        checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
        checkOutput({tag, " busy_cycles"}, 32'(busyCount), 32'd16);
        checkOutput({tag, " sel_mid"}, 32'(selMid), 32'd7);
        checkOutput({tag, " sel_in_done"}, 32'(sel), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_width"}, 32'(done), 32'd0);
        checkOutput({tag, " result_hold"}, 32'(result), 32'(expRes));
    endtask

    initial begin
        int         n;
        int         doneCount;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = 16'h0000;
        b     = 16'h0000;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset sel", 32'(sel), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        rst = 1'b0;

        runOp("add_ffff_1", 2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("add_cin", 2'd0, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0);
        runOp("sub_5_7", 2'd1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        runOp("sub_eq", 2'd1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("sub_cin_ignored", 2'd1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, 1'b0);
        runOp("and", 2'd2, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0);
        runOp("xor", 2'd3, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle hold result", 32'(result), 32'h0FF0);
        checkOutput("idle hold cout", 32'(cout), 32'd0);
        checkOutput("idle busy", 32'(busy), 32'd0);

        runOp("add_disturbed", 2'd0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b1);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'd0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_over_start busy", 32'(busy), 32'd0);

        applyStimulus(2'd0, 16'hFFFF, 16'hFFFF, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("midrun sel", 32'(sel), 32'd8);
        checkOutput("midrun partial", 32'(result), 32'h00FE);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrun_rst busy", 32'(busy), 32'd0);
        checkOutput("midrun_rst result", 32'(result), 32'd0);
        checkOutput("midrun_rst sel", 32'(sel), 32'd0);
        checkOutput("midrun_rst cout", 32'(cout), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) doneCount++;
            @(posedge clk);
            #1;
        end
        checkOutput("midrun_rst no_done", 32'(doneCount), 32'd0);
        runOp("add_after_rst", 2'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // start held high: second acceptance on the IDLE edge after DONE.
        @(negedge clk);
        op    = 2'd0;
        a     = 16'h0001;
        b     = 16'h0002;
        cin   = 1'b0;
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
        checkOutput("held first_latency", 32'(n), 32'd17);
        checkOutput("held first_result", 32'(result), 32'h0003);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
        start = 1'b0;
        checkOutput("held done_spacing", 32'(n), 32'd18);
        checkOutput("held second_result", 32'(result), 32'h0003);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held idle_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
